// File: rtl/systolic_pe_mac.sv
// systolic_pe_mac
// ---------------
// One processing element of the Chebyshev interpolation filter array.
// Each accepted sample is multiplied by the coefficient of the current tap
// with a sequential shift-add multiplier (one multiplier bit per cycle).
// The product is added into a wide accumulator. After TAPS products the
// accumulator is scaled by FRAC_BITS and presented as one output word.
// Every accepted sample is also forwarded to the next PE one cycle later.
//
// Optional feature macro:
//   SYSTOLIC_PE_SAT_EN  defined   -> the scaled result saturates to the
//                                    signed WORDLENGTH range
//                       undefined -> the low WORDLENGTH bits are kept (wrap)
//
// Parameters:
//   WORDLENGTH  sample / coefficient / output width (signed), >= 4
//   TAPS        products accumulated per output, 2..64
//   FRAC_BITS   arithmetic right shift applied to the accumulator
//
// Ports:
//   clk30x       system clock, rising edge
//   reset        synchronous, active-high; also clears the coefficient bank
//   in_data      input sample
//   in_valid     in_data valid
//   in_ready     PE is idle and can take a sample
//   coeff_we     coefficient write strobe (accepted in any state)
//   coeff_addr   coefficient index; indices >= TAPS are ignored
//   coeff_wdata  coefficient value
//   out_data     scaled accumulation result
//   out_valid    out_data valid, held until out_ready
//   out_ready    downstream accepts out_data
//   pass_data    registered copy of the last accepted sample
//   pass_valid   one-cycle pulse accompanying pass_data

module systolic_pe_mac #(
  parameter int WORDLENGTH = 16,
  parameter int TAPS       = 8,
  parameter int FRAC_BITS  = 15
) (
  input  logic                    clk30x,
  input  logic                    reset,
  input  logic [WORDLENGTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    coeff_we,
  input  logic [$clog2(TAPS)-1:0] coeff_addr,
  input  logic [WORDLENGTH-1:0]   coeff_wdata,
  output logic [WORDLENGTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDLENGTH-1:0]   pass_data,
  output logic                    pass_valid
);

  localparam int W    = WORDLENGTH;
  localparam int AW   = $clog2(TAPS);
  localparam int SW   = $clog2(W);
  localparam int PW   = 2 * W;
  // Sum of TAPS full-range products needs clog2(TAPS) guard bits.
  localparam int ACCW = PW + AW;

  localparam logic [AW:0]   TAPS_AW  = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  typedef enum logic [1:0] {IDLE, MULT, ACC, OUT} state_t;

  state_t state_q, state_d;

  logic [W-1:0]    coeff [TAPS];
  logic [PW-1:0]   mcand;     // sample, sign-extended, shifted left per step
  logic [W-1:0]    mplier;    // coefficient, shifted right per step
  logic [PW-1:0]   prod;
  logic [SW-1:0]   step;
  logic [AW-1:0]   tap_idx;
  logic [ACCW-1:0] acc;

  logic            accept;
  logic            last_step;
  logic            last_tap;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] acc_sum;
  logic [ACCW-1:0] shifted;
  logic [W-1:0]    out_word;

  assign last_step = (step == LAST_STEP);
  assign last_tap  = (tap_idx == LAST_TAP);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk30x) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MULT;
      MULT:    if (last_step) state_d = ACC;
      ACC:     state_d = last_tap ? OUT : IDLE;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q == IDLE) && !reset;
    accept   = in_valid && in_ready;
  end

  // ---------------------------------------------------------------------
  // Accumulate and output formation
  // ---------------------------------------------------------------------
  assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
  assign acc_sum  = acc + prod_ext;
  assign shifted  = $signed(acc_sum) >>> FRAC_BITS;

`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic [ACCW-1:0] SAT_MAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [ACCW-1:0] SAT_MIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    out_word = shifted[W-1:0];
    if ($signed(shifted) > $signed(SAT_MAX))      out_word = SAT_MAX[W-1:0];
    else if ($signed(shifted) < $signed(SAT_MIN)) out_word = SAT_MIN[W-1:0];
  end
`else
  // Two's-complement wrap: upper bits of the scaled sum are dropped.
  logic unused_shift_hi;
  assign unused_shift_hi = ^shifted[ACCW-1:W];
  assign out_word        = shifted[W-1:0];
`endif

  // ---------------------------------------------------------------------
  // Coefficient bank. The acceptance reads the registered value, so a
  // write on the same edge only affects later products.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk30x) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coeff[i] <= '0;
    end else if (coeff_we && ({1'b0, coeff_addr} < TAPS_AW)) begin
      coeff[coeff_addr] <= coeff_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk30x) begin
    if (reset) begin
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      step       <= '0;
      tap_idx    <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      pass_data  <= '0;
      pass_valid <= 1'b0;
    end else begin
      pass_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mcand      <= {{W{in_data[W-1]}}, in_data};
            mplier     <= coeff[tap_idx];
            prod       <= '0;
            step       <= '0;
            pass_data  <= in_data;
            pass_valid <= 1'b1;
          end
        end
        MULT: begin
          // Bit i of the multiplier weighs +2^i, except the sign bit which
          // weighs -2^(W-1); subtracting on the last step yields the exact
          // signed product without a correction cycle.
          if (mplier[0]) begin
            if (last_step) prod <= prod - mcand;
            else           prod <= prod + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + SW'(1);
        end
        ACC: begin
          if (last_tap) begin
            out_data  <= out_word;
            out_valid <= 1'b1;
            acc       <= '0;
            tap_idx   <= '0;
          end else begin
            acc       <= acc_sum;
            tap_idx   <= tap_idx + AW'(1);
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
`timescale 1ns/1ps
module tb_systolic_pe_mac;
  localparam int W    = 16;
  localparam int TAPS = 4;
  localparam int FB   = 15;
  localparam int AW   = 2;

  logic          clk30x = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          coeff_we;
  logic [AW-1:0] coeff_addr;
  logic [W-1:0]  coeff_wdata;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  pass_data;
  logic          pass_valid;

  systolic_pe_mac #(.WORDLENGTH(W), .TAPS(TAPS), .FRAC_BITS(FB)) dut (
    .clk30x(clk30x), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pass_data(pass_data), .pass_valid(pass_valid)
  );

  always #5 clk30x = ~clk30x;

  int cyc = 0;
  initial forever begin
    @(posedge clk30x);
    cyc++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  typedef struct { logic [W-1:0] data; int cyc; } pass_t;

  longint       m_coeff [TAPS];
  longint       m_acc;
  int           m_tap;
  pass_t        pass_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] last_out;
  bit           lat_chk = 0;
  bit           lat_wait = 0;
  int           lat_exp;
  int           acc_edge;
  bit           rand_bp = 0;

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Scale by 2^-FB with floor, then saturate or wrap to W bits.
  function automatic logic [W-1:0] form(input longint acc);
    longint sh;
    sh = acc >>> FB;
`ifdef SYSTOLIC_PE_SAT_EN
    if (sh > 32767)       sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return sh[W-1:0];
  endfunction

  // Monitor / scoreboard: samples at negedge, away from the active edge.
  initial forever begin
    @(negedge clk30x);
    if (pass_valid) begin
      if (pass_q.size() == 0) fail_now("pass_unexpected", $sformatf("got pulse with 0x%0h, expected none", pass_data));
      else begin
        pass_t p;
        p = pass_q.pop_front();
        check("pass_data", pass_data, p.data);
        check("pass_lat", cyc, p.cyc);
      end
    end else if (pass_q.size() > 0 && pass_q[0].cyc < cyc) begin
      fail_now("pass_missing", $sformatf("no pulse at cycle %0d, expected data 0x%0h", pass_q[0].cyc, pass_q[0].data));
      void'(pass_q.pop_front());
    end

    if (out_valid && out_ready) begin
      last_out = out_data;
      if (out_q.size() == 0) fail_now("out_unexpected", $sformatf("got 0x%0h, expected no output", out_data));
      else check("out_data", out_data, out_q.pop_front());
    end

    if (lat_wait && in_ready) begin
      check("ready_lat", cyc - acc_edge, lat_exp);
      lat_wait = 0;
    end

    if (!reset && in_valid && in_ready) begin
      pass_q.push_back('{data: in_data, cyc: cyc + 1});
      m_acc += sx(in_data) * m_coeff[m_tap];
      lat_exp  = (m_tap == TAPS-1) ? 18 : 17;
      acc_edge = cyc + 1;
      lat_wait = lat_chk;
      if (m_tap == TAPS-1) begin
        out_q.push_back(form(m_acc));
        m_acc = 0;
        m_tap = 0;
      end else m_tap++;
    end

    if (!reset && coeff_we) m_coeff[coeff_addr] = sx(coeff_wdata);

    if (reset) begin
      for (int i = 0; i < TAPS; i++) m_coeff[i] = 0;
      m_acc = 0;
      m_tap = 0;
      pass_q.delete();
      out_q.delete();
      lat_wait = 0;
    end
  end

  // Random output backpressure when enabled.
  initial forever begin
    @(posedge clk30x);
    #2;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk30x);
    #1;
  endtask

  task automatic write_coeff(input int a, input logic [W-1:0] d);
    coeff_we = 1'b1;
    coeff_addr = AW'(a);
    coeff_wdata = d;
    tick();
    coeff_we = 1'b0;
  endtask

  task automatic load_all(input logic [W-1:0] d);
    for (int i = 0; i < TAPS; i++) write_coeff(i, d);
  endtask

  task automatic send(input logic [W-1:0] d, input bit keep);
    int t;
    t = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) fail_now("send_timeout", $sformatf("in_ready low for %0d cycles, expected high", t));
    else tick();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((out_q.size() != 0 || pass_q.size() != 0 || out_valid) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) fail_now("drain_timeout", $sformatf("%0d outputs still pending, expected 0", out_q.size()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pass_data"}, pass_data, 0);
    check({tag, "_pass_valid"}, pass_valid, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] hold;
    int t;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; coeff_we = 1'b0;
    coeff_addr = '0; coeff_wdata = '0; out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Basic MAC
    load_all(16'h4000);
    for (int i = 0; i < TAPS; i++) send(16'h2000, 0);
    drain();
    check("basic_out", last_out, 16'h4000);

    // Overflow
    load_all(16'h7FFF);
    for (int i = 0; i < TAPS; i++) send(16'h7FFF, 0);
    drain();
`ifdef SYSTOLIC_PE_SAT_EN
    check("overflow_out", last_out, 16'h7FFF);
`else
    check("overflow_out", last_out, 16'hFFF8);
`endif

    // Negative corner
    write_coeff(0, 16'h8000);
    for (int i = 1; i < TAPS; i++) write_coeff(i, 16'h0000);
    send(16'h8000, 0);
    for (int i = 1; i < TAPS; i++) send(16'h0000, 0);
    drain();
`ifdef SYSTOLIC_PE_SAT_EN
    check("negcorner_out", last_out, 16'h7FFF);
`else
    check("negcorner_out", last_out, 16'h8000);
`endif

    // Latency with in_valid held high
    for (int i = 0; i < TAPS; i++) write_coeff(i, W'($urandom));
    lat_chk = 1;
    for (int i = 0; i < 2*TAPS; i++) send(W'($urandom), 1);
    in_valid = 1'b0;
    drain();
    lat_chk = 0;

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) send(W'($urandom), 0);
    t = 0;
    while (!out_valid && t < 100) begin tick(); t++; end
    if (!out_valid) fail_now("bp_wait", "out_valid never rose, expected high");
    hold = out_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
      tick();
      check("bp_out_stable", out_data, hold);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    drain();

    // Reset mid-frame
    load_all(16'h1234);
    send(16'h0777, 0);
    send(16'h0555, 0);
    reset = 1'b1;
    tick();
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    load_all(16'h4000);
    for (int i = 0; i < TAPS; i++) send(16'h2000, 0);
    drain();
    check("midrst_out", last_out, 16'h4000);

    // Random traffic with coefficient writes and random backpressure
    rand_bp = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        coeff_we = 1'b1;
        coeff_addr = AW'($urandom);
        coeff_wdata = W'($urandom);
      end
      send(W'($urandom), 0);
      coeff_we = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_bp = 0;
    #3;
    drain();
    check("final_out_q_empty", out_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000ns, expected finish");
    $fatal(1);
  end
endmodule
